// File: rtl/spi_peripheral_pkg.sv
// Shared definitions for the SPI register bank: addresses, frame layout, FSM states.
package spi_pkg;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
  localparam logic [6:0] MAX_ADDR         = 7'h04;

  localparam int         FRAME_BITS = 16;
  localparam int         NUM_REGS   = 5;
  localparam logic [4:0] CNT_FULL   = 5'd16;
  localparam logic [4:0] CNT_SAT    = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    COMMIT = 2'b10
  } state_t;

  // Frame as it lands in the shift register, MSB first.
  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } frame_t;

  // A frame may update a register only if it is a complete write to a mapped address.
  function automatic logic frame_writable(input frame_t f, input logic [4:0] cnt);
    return (cnt == CNT_FULL) && f.rw && (f.addr <= MAX_ADDR);
  endfunction

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pin bundle; the controller drives it, the register bank only listens.
interface spi_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_peripheral_sync_ff.sv
// Multi-stage synchronizer bringing one asynchronous pin into the clk domain.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_q;

  // Shift the pin value through the flop chain; synchronous clear to 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_q <= '0;
    else        r_q <= {r_q[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register bank holding the PWM stage control registers.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_peripheral_if.slave        bus,
  output logic [7:0]             en_reg_out_7_0,
  output logic [7:0]             en_reg_out_15_8,
  output logic [7:0]             en_reg_pwm_7_0,
  output logic [7:0]             en_reg_pwm_15_8,
  output logic [7:0]             pwm_duty_cycle
);

  logic w_sclk_s, w_copi_s, w_ncs_s;
  logic r_sclk_d, r_ncs_d;
  logic w_sclk_rise, w_ncs_rise;

  state_t r_state, w_next_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [4:0]            r_cnt;
  logic [7:0]            r_regs [NUM_REGS];

  logic   w_shift_en, w_cnt_clr, w_commit;
  frame_t w_frame;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .i_d(bus.sclk), .o_q(w_sclk_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (.clk(clk), .rst_n(rst_n), .i_d(bus.copi), .o_q(w_copi_s));
  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs  (.clk(clk), .rst_n(rst_n), .i_d(bus.ncs),  .o_q(w_ncs_s));

  // Delay the synchronized sclk/ncs by one cycle for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_d <= 1'b0;
      r_ncs_d  <= 1'b0;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_ncs_d  <= w_ncs_s;
    end
  end

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_ncs_rise  = w_ncs_s  & ~r_ncs_d;
  assign w_frame     = frame_t'(r_shift);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (!w_ncs_s)  w_next_state = SHIFT;
      SHIFT:   if (w_ncs_rise) w_next_state = COMMIT;
      COMMIT:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs; a simultaneous ncs rise suppresses the sclk edge.
  always_comb begin
    w_shift_en = 1'b0;
    w_cnt_clr  = 1'b0;
    w_commit   = 1'b0;
    unique case (r_state)
      IDLE:    w_cnt_clr  = 1'b1;
      SHIFT:   w_shift_en = w_sclk_rise & ~w_ncs_rise;
      COMMIT:  w_commit   = frame_writable(w_frame, r_cnt);
      default: ;
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_cnt_clr) begin
      r_cnt   <= '0;
    end else if (w_shift_en) begin
      r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_s};
      if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 5'd1;
    end
  end

  // Register bank write on a valid committed frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: this small register file drives outputs directly, so every entry is reset, unlike a RAM.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_frame.addr == 7'(i)) r_regs[i] <= w_frame.data;
    end
  end

  assign en_reg_out_7_0  = r_regs[ADDR_EN_OUT_7_0];
  assign en_reg_out_15_8 = r_regs[ADDR_EN_OUT_15_8];
  assign en_reg_pwm_7_0  = r_regs[ADDR_EN_PWM_7_0];
  assign en_reg_pwm_15_8 = r_regs[ADDR_EN_PWM_15_8];
  assign pwm_duty_cycle  = r_regs[ADDR_PWM_DUTY];

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: reset, writes, rejected frames, abort, random frames.
module tb_spi_peripheral;
  import spi_pkg::*;

  localparam int HALF = 3;   // clk periods per sclk phase (minimum legal)
  localparam int GAP  = 4;   // clk periods of ncs high between frames

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] o0, o1, o2, o3, o4;
  logic [7:0] m [5];
  int checks = 0;
  int errors = 0;

  spi_peripheral_if bus ();

  spi_peripheral #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .en_reg_out_7_0(o0), .en_reg_out_15_8(o1), .en_reg_pwm_7_0(o2),
    .en_reg_pwm_15_8(o3), .pwm_duty_cycle(o4)
  );

  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/r0"}, o0, m[0]);
    check({tag, "/r1"}, o1, m[1]);
    check({tag, "/r2"}, o2, m[2]);
    check({tag, "/r3"}, o3, m[3]);
    check({tag, "/r4"}, o4, m[4]);
  endtask

  // Shift nbits of val MSB first with ncs low; leaves sclk low after a full low phase.
  task automatic shift_bits(input logic [31:0] val, input int nbits);
    bus.ncs = 1'b0;
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.sclk = 1'b0;
      bus.copi = val[i];
      wait_clks(HALF);
      bus.sclk = 1'b1;
      wait_clks(HALF);
    end
    bus.sclk = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic end_frame();
    bus.ncs = 1'b1;
    wait_clks(GAP);
  endtask

  task automatic send(input logic [31:0] val, input int nbits);
    shift_bits(val, nbits);
    end_frame();
  endtask

  initial begin
    logic [15:0] f;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    bus.sclk = 1'b0; bus.copi = 1'b0; bus.ncs = 1'b1;

    // Reset with pins toggling.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.sclk = ~bus.sclk; bus.copi = ~bus.copi; bus.ncs = ~bus.ncs;
    end
    bus.sclk = 1'b0; bus.copi = 1'b0; bus.ncs = 1'b1;
    @(posedge clk); #1;
    check_all("reset");
    check("reset/state", 8'(dut.r_state), 8'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    wait_clks(GAP);
    check("post_reset/state", 8'(dut.r_state), 8'(IDLE));

    // First write with latency check: unchanged at k+2, updated at k+3.
    shift_bits(32'h80F0, 16);
    bus.ncs = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("latency/k+2", o0, 8'h00);
    @(posedge clk);
    #1 check("latency/k+3", o0, 8'hF0);
    m[0] = 8'hF0;
    wait_clks(GAP);
    check_all("write_80F0");

    send(32'h8480, 16); m[4] = 8'h80;
    check_all("write_8480");

    // Rejected frames.
    send(32'h00AA, 16);
    check_all("read_00AA");
    send(32'h8555, 16);
    check_all("addr_05");
    send(32'h8177 >> 1, 15);
    check_all("short_15");
    send({15'd0, 16'h80F1, 1'b1}, 17);
    check_all("long_17");
    send(32'hFF12, 16);
    check_all("addr_7F");

    // Back-to-back writes to every register.
    send(32'h8011, 16); m[0] = 8'h11;
    send(32'h8122, 16); m[1] = 8'h22;
    send(32'h8233, 16); m[2] = 8'h33;
    send(32'h8344, 16); m[3] = 8'h44;
    send(32'h84FF, 16); m[4] = 8'hFF;
    check_all("b2b");

    // Mid-frame abort.
    send(32'h815A, 16); m[1] = 8'h5A;
    check_all("pre_abort");
    shift_bits(32'h81, 8);
    rst_n = 1'b0;
    wait_clks(3);
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    check_all("abort_reset");
    rst_n = 1'b1;
    wait_clks(2);
    shift_bits(32'hAB, 8);
    end_frame();
    check_all("abort_finish");

    // Random frames at minimum sclk phase against the model.
    for (int n = 0; n < 100; n++) begin
      f = 16'($urandom);
      f[14:8] = 7'($urandom_range(0, 7));
      send({16'd0, f}, 16);
      if (f[15] && f[14:8] <= 7'h04) m[f[10:8]] = f[7:0];
      check_all($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
